multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: a Moore FSM that sequences fetch,
// decode, memory, execute and writeback steps for R-type, addi/andi/ori,
// lw, sw and beq. Unsupported opcodes pass through an ILLEGAL state.
// All outputs, including the debug state, are held at 0 while rst_n is low.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_FUNCT = 3'b100;

  state_t state_reg;
  state_t state_next;

  // ALU operation for the immediate-arithmetic group, shared by EXEC_I and I_WB
  // so the result stays stable through writeback.
  function automatic logic [2:0] imm_aluop(input logic [5:0] op);
    case (op)
      OP_ANDI: imm_aluop = ALU_AND;
      OP_ORI:  imm_aluop = ALU_OR;
      default: imm_aluop = ALU_ADD;
    endcase
  endfunction

  // State register; reset always lands in FETCH.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= S_FETCH;
    else        state_reg <= state_next;
  end

  // Next-state and control decode; everything stays 0 while in reset or in an
  // unused state code, which simply falls back to FETCH.
  always_comb begin
    state_next  = S_FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = 3'b000;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    if (rst_n) begin
      case (state_reg)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          ALUOp   = ALU_ADD;
          if (mem_ready) begin
            IRWrite    = 1'b1;
            PCWrite    = 1'b1;
            state_next = S_DECODE;
          end else begin
            state_next = S_FETCH;
          end
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          ALUOp   = ALU_ADD;
          case (opcode)
            OP_RTYPE:                  state_next = S_EXEC_R;
            OP_ADDI, OP_ANDI, OP_ORI:  state_next = S_EXEC_I;
            OP_LW, OP_SW:              state_next = S_MEM_ADDR;
            OP_BEQ:                    state_next = S_BRANCH;
            default:                   state_next = S_ILLEGAL;
          endcase
        end
        S_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = ALU_ADD;
          // An opcode that stopped being a load/store here is flagged, not executed.
          case (opcode)
            OP_LW:   state_next = S_MEM_RD;
            OP_SW:   state_next = S_MEM_WR;
            default: state_next = S_ILLEGAL;
          endcase
        end
        S_MEM_RD: begin
          MemRead    = 1'b1;
          IorD       = 1'b1;
          state_next = mem_ready ? S_MEM_WB : S_MEM_RD;
        end
        S_MEM_WB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
          state_next = S_FETCH;
        end
        S_MEM_WR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
          state_next = mem_ready ? S_FETCH : S_MEM_WR;
        end
        S_EXEC_R: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b00;
          ALUOp      = ALU_FUNCT;
          state_next = S_R_WB;
        end
        S_R_WB: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          instr_done = 1'b1;
          state_next = S_FETCH;
        end
        S_EXEC_I: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          ALUOp      = imm_aluop(opcode);
          state_next = S_I_WB;
        end
        S_I_WB: begin
          RegWrite   = 1'b1;
          ALUOp      = imm_aluop(opcode);
          instr_done = 1'b1;
          state_next = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUSrcB     = 2'b00;
          ALUOp       = ALU_SUB;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          instr_done  = 1'b1;
          state_next  = S_FETCH;
        end
        S_ILLEGAL: begin
          illegal    = 1'b1;
          instr_done = 1'b1;
          state_next = S_FETCH;
        end
        default: state_next = S_FETCH;
      endcase
    end
  end

  // Debug view of the state, forced to 0 during reset like every other output.
  assign state = rst_n ? state_reg : 4'd0;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a per-cycle vector table covering
// reset, every instruction class, memory waits and mid-instruction reset,
// followed by latency measurements with mem_ready tied high.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegWrite, RegDst, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic       instr_done, illegal;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .instr_done(instr_done), .illegal(illegal),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control bundle, MSB first:
  // PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegWrite RegDst
  // ALUSrcA ALUSrcB[1:0] PCSource[1:0] ALUOp[2:0] instr_done illegal
  function automatic logic [18:0] pk(
    input logic pcw, pcwc, iord, mr, mw, irw, m2r, rw, rd, asa,
    input logic [1:0] asb, pcs, input logic [2:0] aop, input logic done, ill);
    pk = {pcw, pcwc, iord, mr, mw, irw, m2r, rw, rd, asa, asb, pcs, aop, done, ill};
  endfunction

  function automatic logic [18:0] dut_ctl();
    dut_ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp, instr_done, illegal};
  endfunction

  typedef struct {
    logic       rst_n;
    logic [5:0] op;
    logic       rdy;
    logic [3:0] st;
    logic [18:0] ctl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [5:0] op, input logic rdy,
                     input logic [3:0] st, input logic [18:0] ctl);
    vec_t v;
    v.rst_n = r; v.op = op; v.rdy = rdy; v.st = st; v.ctl = ctl;
    vecs.push_back(v);
  endtask

  // Hand-derived expected control words per cycle type
  logic [18:0] C_ZERO, C_F_RDY, C_F_WAIT, C_DEC, C_MADDR, C_MRD, C_MWB;
  logic [18:0] C_MWR_W, C_MWR_D, C_EXR, C_RWB, C_EXI_AND, C_EXI_OR, C_EXI_ADD;
  logic [18:0] C_IWB_AND, C_IWB_OR, C_IWB_ADD, C_BR, C_ILL;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, ANDI = 6'b001100;
  localparam logic [5:0] ORI = 6'b001101, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, BAD = 6'b111111;

  // Safety invariants checked on every sampled cycle
  always @(negedge clk) begin
    checks++;
    if ((MemRead && MemWrite) || (RegWrite && MemWrite)) begin
      errors++;
      $display("FAIL mem_excl: MemRead=%b MemWrite=%b RegWrite=%b, required no overlap",
               MemRead, MemWrite, RegWrite);
    end
  end

  task automatic run_instr(input logic [5:0] op, input int exp_lat);
    int cycles;
    logic [3:0] first_st;
    rst_n = 1'b1; opcode = op; mem_ready = 1'b1;
    cycles = 0;
    first_st = 4'hf;
    forever begin
      @(negedge clk);
      if (cycles == 0) first_st = state;
      cycles++;
      if (instr_done || cycles > 20) break;
      @(posedge clk); #1;
    end
    checks++;
    if (cycles != exp_lat || first_st != 4'd0) begin
      errors++;
      $display("FAIL latency op=%b: got %0d cycles (start state %0d), required %0d cycles from state 0",
               op, cycles, first_st, exp_lat);
    end else begin
      $display("instr op=%b latency %0d cycles", op, cycles);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    C_ZERO    = '0;
    C_F_RDY   = pk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,3'b010,0,0);
    C_F_WAIT  = pk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,3'b010,0,0);
    C_DEC     = pk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,0);
    C_MADDR   = pk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0);
    C_MRD     = pk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,0);
    C_MWB     = pk(0,0,0,0,0,0,1,1,0,0,2'b00,2'b00,3'b000,1,0);
    C_MWR_W   = pk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,3'b000,0,0);
    C_MWR_D   = pk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,3'b000,1,0);
    C_EXR     = pk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b100,0,0);
    C_RWB     = pk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,3'b000,1,0);
    C_EXI_AND = pk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b000,0,0);
    C_EXI_OR  = pk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b001,0,0);
    C_EXI_ADD = pk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0);
    C_IWB_AND = pk(0,0,0,0,0,0,0,1,0,0,2'b00,2'b00,3'b000,1,0);
    C_IWB_OR  = pk(0,0,0,0,0,0,0,1,0,0,2'b00,2'b00,3'b001,1,0);
    C_IWB_ADD = pk(0,0,0,0,0,0,0,1,0,0,2'b00,2'b00,3'b010,1,0);
    C_BR      = pk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b011,1,0);
    C_ILL     = pk(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b000,1,1);

    // reset, two cycles
    add(0, RT, 1, 0, C_ZERO);      add(0, RT, 1, 0, C_ZERO);
    // lw, no waits
    add(1, LW, 1, 0, C_F_RDY);     add(1, LW, 1, 1, C_DEC);
    add(1, LW, 1, 2, C_MADDR);     add(1, LW, 1, 3, C_MRD);
    add(1, LW, 1, 4, C_MWB);
    // sw, three wait cycles in MEM_WR
    add(1, SW, 1, 0, C_F_RDY);     add(1, SW, 1, 1, C_DEC);
    add(1, SW, 1, 2, C_MADDR);     add(1, SW, 0, 5, C_MWR_W);
    add(1, SW, 0, 5, C_MWR_W);     add(1, SW, 0, 5, C_MWR_W);
    add(1, SW, 1, 5, C_MWR_D);
    // andi with one fetch wait
    add(1, ANDI, 0, 0, C_F_WAIT);  add(1, ANDI, 1, 0, C_F_RDY);
    add(1, ANDI, 1, 1, C_DEC);     add(1, ANDI, 1, 8, C_EXI_AND);
    add(1, ANDI, 1, 9, C_IWB_AND);
    // ori
    add(1, ORI, 1, 0, C_F_RDY);    add(1, ORI, 1, 1, C_DEC);
    add(1, ORI, 1, 8, C_EXI_OR);   add(1, ORI, 1, 9, C_IWB_OR);
    // R-type
    add(1, RT, 1, 0, C_F_RDY);     add(1, RT, 1, 1, C_DEC);
    add(1, RT, 1, 6, C_EXR);       add(1, RT, 1, 7, C_RWB);
    // beq, then illegal opcode
    add(1, BEQ, 1, 0, C_F_RDY);    add(1, BEQ, 1, 1, C_DEC);
    add(1, BEQ, 1, 10, C_BR);
    add(1, BAD, 1, 0, C_F_RDY);    add(1, BAD, 1, 1, C_DEC);
    add(1, BAD, 1, 11, C_ILL);
    // addi, opcode garbage during FETCH and R-type during EXEC_R-free cycles
    add(1, BEQ, 1, 0, C_F_RDY);    add(1, ADDI, 1, 1, C_DEC);
    add(1, ADDI, 1, 8, C_EXI_ADD); add(1, ADDI, 1, 9, C_IWB_ADD);
    // lw with two MEM_RD waits
    add(1, LW, 1, 0, C_F_RDY);     add(1, LW, 1, 1, C_DEC);
    add(1, LW, 1, 2, C_MADDR);     add(1, LW, 0, 3, C_MRD);
    add(1, LW, 0, 3, C_MRD);       add(1, LW, 1, 3, C_MRD);
    add(1, LW, 1, 4, C_MWB);
    // reset during MEM_RD wait, then a clean fetch
    add(1, LW, 1, 0, C_F_RDY);     add(1, LW, 1, 1, C_DEC);
    add(1, LW, 1, 2, C_MADDR);     add(1, LW, 0, 3, C_MRD);
    add(0, LW, 1, 0, C_ZERO);      add(1, LW, 1, 0, C_F_RDY);
    add(1, LW, 1, 1, C_DEC);       add(1, LW, 1, 2, C_MADDR);
    add(1, LW, 1, 3, C_MRD);       add(1, LW, 1, 4, C_MWB);
    // reset during MEM_WR wait, then a clean R-type
    add(1, SW, 1, 0, C_F_RDY);     add(1, SW, 1, 1, C_DEC);
    add(1, SW, 1, 2, C_MADDR);     add(1, SW, 0, 5, C_MWR_W);
    add(0, SW, 0, 0, C_ZERO);      add(1, RT, 1, 0, C_F_RDY);
    add(1, RT, 1, 1, C_DEC);       add(1, RT, 1, 6, C_EXR);
    add(1, RT, 1, 7, C_RWB);

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n; opcode = vecs[i].op; mem_ready = vecs[i].rdy;
      @(negedge clk);
      checks += 2;
      if (state !== vecs[i].st) begin
        errors++;
        $display("FAIL row%0d state: got %0d, required %0d", i, state, vecs[i].st);
      end
      if (dut_ctl() !== vecs[i].ctl) begin
        errors++;
        $display("FAIL row%0d ctl: got %b, required %b", i, dut_ctl(), vecs[i].ctl);
      end
      $display("row %0d rst_n=%b op=%b rdy=%b state=%0d ctl=%b",
               i, rst_n, opcode, mem_ready, state, dut_ctl());
      @(posedge clk); #1;
    end

    // Latency with mem_ready tied high, starting from FETCH
    run_instr(RT, 4);
    run_instr(ADDI, 4);
    run_instr(ANDI, 4);
    run_instr(ORI, 4);
    run_instr(LW, 5);
    run_instr(SW, 4);
    run_instr(BEQ, 3);
    run_instr(BAD, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
